traffic_light_ctrl: RTL and testbench

- Parametrised two-road intersection controller; successor to the single-direction light counter.
- Sequences main road A and side road B through green, yellow and all-red phases with configurable durations.
- Adds a latched pedestrian-request handshake served in a dedicated walk phase.
- Sits between the board timing tick domain and the lamp drivers; `enable` gates the whole sequence.

---
 rtl/tl_pkg.sv | 26 ++
 rtl/phase_timer.sv | 38 +++
 rtl/traffic_light_ctrl.sv | 137 +++++++++++++
 tb/tb_traffic_light_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// ---------------------------------------------------------------------------
// Module   : tl_pkg
// Brief    : Shared state encoding and lamp codes for traffic_light_ctrl.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tl_pkg;

  typedef enum logic [2:0] {
    ALLRED_A = 3'd0,
    A_GREEN  = 3'd1,
    A_YELLOW = 3'd2,
    ALLRED_B = 3'd3,
    B_GREEN  = 3'd4,
    B_YELLOW = 3'd5,
    WALK     = 3'd6
  } tl_state_e;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

endpackage

`default_nettype wire

// File: rtl/phase_timer.sv
// ---------------------------------------------------------------------------
// Module   : phase_timer
// Brief    : Elapsed-cycle counter for one phase; strobes done on its last cycle.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] last,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] r_count;

  assign done  = (r_count == last);
  assign count = r_count;

  // Wrapping on done keeps the counter aligned with the state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= done ? '0 : r_count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
// ---------------------------------------------------------------------------
// Module   : traffic_light_ctrl
// Brief    : Two-road intersection sequencer with latched pedestrian walk phase.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module traffic_light_ctrl
  import tl_pkg::*;
#(
  parameter int GREEN_TICKS  = 10,
  parameter int YELLOW_TICKS = 5,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 8,
  parameter int CNT_W        = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             ped_req,
  output logic [2:0]       light_a,
  output logic [2:0]       light_b,
  output logic             ped_walk,
  output logic             ped_ack,
  output logic [CNT_W-1:0] count,
  output logic [2:0]       phase
);

  generate
    if ((GREEN_TICKS < 1) || (YELLOW_TICKS < 1) || (ALLRED_TICKS < 1) || (WALK_TICKS < 1) ||
        (GREEN_TICKS > (1 << CNT_W)) || (YELLOW_TICKS > (1 << CNT_W)) ||
        (ALLRED_TICKS > (1 << CNT_W)) || (WALK_TICKS > (1 << CNT_W))) begin : g_bad_params
      $fatal(1, "traffic_light_ctrl: phase durations must be >=1 and fit in CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] c_green_last  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] c_yellow_last = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] c_allred_last = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] c_walk_last   = CNT_W'(WALK_TICKS - 1);

  tl_state_e        r_state;
  tl_state_e        w_next;
  logic             r_ped_pending;
  logic             r_ret_b;
  logic             r_ped_ack;
  logic             w_done;
  logic             w_enter_walk;
  logic [CNT_W-1:0] w_last;

  always_comb begin
    w_last = c_allred_last;
    case (r_state)
      A_GREEN, B_GREEN:   w_last = c_green_last;
      A_YELLOW, B_YELLOW: w_last = c_yellow_last;
      WALK:               w_last = c_walk_last;
      default:            w_last = c_allred_last;
    endcase
  end

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (enable),
    .clr  (~enable),
    .last (w_last),
    .count(count),
    .done (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ALLRED_A;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = ALLRED_A;
    end else if (w_done) begin
      case (r_state)
        ALLRED_A: w_next = r_ped_pending ? WALK : A_GREEN;
        A_GREEN:  w_next = A_YELLOW;
        A_YELLOW: w_next = ALLRED_B;
        ALLRED_B: w_next = r_ped_pending ? WALK : B_GREEN;
        B_GREEN:  w_next = B_YELLOW;
        B_YELLOW: w_next = ALLRED_A;
        WALK:     w_next = r_ret_b ? B_GREEN : A_GREEN;
        default:  w_next = ALLRED_A;
      endcase
    end
  end

  assign w_enter_walk = (w_next == WALK) && (r_state != WALK);

  // Entering WALK serves the request, so the clear beats a coincident ped_req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ped_pending <= 1'b0;
      r_ret_b       <= 1'b0;
      r_ped_ack     <= 1'b0;
    end else begin
      r_ped_ack <= w_enter_walk;
      if (w_enter_walk) begin
        r_ped_pending <= 1'b0;
        r_ret_b       <= (r_state == ALLRED_B);
      end else if (ped_req && (r_state != WALK)) begin
        r_ped_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    light_a  = LAMP_RED;
    light_b  = LAMP_RED;
    ped_walk = 1'b0;
    case (r_state)
      A_GREEN:  light_a  = LAMP_GREEN;
      A_YELLOW: light_a  = LAMP_YELLOW;
      B_GREEN:  light_b  = LAMP_GREEN;
      B_YELLOW: light_b  = LAMP_YELLOW;
      WALK:     ped_walk = 1'b1;
      default:  ;
    endcase
  end

  assign ped_ack = r_ped_ack;
  assign phase   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
// ---------------------------------------------------------------------------
// Module   : tb_traffic_light_ctrl
// Brief    : Segment-table checks of traffic_light_ctrl at default and small timings.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_traffic_light_ctrl;
  import tl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, enable, ped_req;
  logic [2:0] light_a, light_b, phase;
  logic       ped_walk, ped_ack;
  logic [4:0] count;

  logic       rst2_n, en2, req2;
  logic [2:0] light_a2, light_b2, phase2;
  logic       ped_walk2, ped_ack2;
  logic [1:0] count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ped_req(ped_req),
    .light_a(light_a), .light_b(light_b), .ped_walk(ped_walk),
    .ped_ack(ped_ack), .count(count), .phase(phase)
  );

  traffic_light_ctrl #(
    .GREEN_TICKS(3), .YELLOW_TICKS(1), .ALLRED_TICKS(1), .WALK_TICKS(2), .CNT_W(2)
  ) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .enable(en2), .ped_req(req2),
    .light_a(light_a2), .light_b(light_b2), .ped_walk(ped_walk2),
    .ped_ack(ped_ack2), .count(count2), .phase(phase2)
  );

  typedef struct {
    tl_state_e st;
    int        n;
    int        cnt0;
    bit        inc;
    bit        en;
    bit        req;
    bit        ack;
  } seg_t;

  seg_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_a(tl_state_e s);
    return (s == A_GREEN) ? 3'b001 : (s == A_YELLOW) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] exp_b(tl_state_e s);
    return (s == B_GREEN) ? 3'b001 : (s == B_YELLOW) ? 3'b010 : 3'b100;
  endfunction

  function automatic void add(tl_state_e st, int n, int c0, bit inc, bit en, bit req, bit ack);
    seg_t s;
    s.st = st; s.n = n; s.cnt0 = c0; s.inc = inc; s.en = en; s.req = req; s.ack = ack;
    tbl.push_back(s);
  endfunction

  // Each cycle: check what the DUT shows now, then drive inputs for the coming edge.
  task automatic run_seg(input seg_t s);
    for (int i = 0; i < s.n; i++) begin
      @(negedge clk);
      chk("phase",    int'(phase),    int'(s.st));
      chk("count",    int'(count),    s.inc ? s.cnt0 + i : s.cnt0);
      chk("light_a",  int'(light_a),  int'(exp_a(s.st)));
      chk("light_b",  int'(light_b),  int'(exp_b(s.st)));
      chk("ped_walk", int'(ped_walk), int'(s.st == WALK));
      chk("ped_ack",  int'(ped_ack),  int'(s.ack && i == 0));
      enable  = s.en;
      ped_req = s.req;
    end
  endtask

  task automatic seg(input tl_state_e st, input int n, input int c0, input bit req, input bit ack);
    seg_t s;
    s.st = st; s.n = n; s.cnt0 = c0; s.inc = 1'b1; s.en = 1'b1; s.req = req; s.ack = ack;
    run_seg(s);
  endtask

  // Reset lands between clock edges; enable stays low so release leaves ALLRED_A at 0.
  task automatic async_reset(input string tag);
    @(negedge clk);
    ped_req = 1'b0;
    enable  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_phase"},   int'(phase),    int'(ALLRED_A));
    chk({tag, "_count"},   int'(count),    0);
    chk({tag, "_light_a"}, int'(light_a),  4);
    chk({tag, "_light_b"}, int'(light_b),  4);
    chk({tag, "_walk"},    int'(ped_walk), 0);
    chk({tag, "_ack"},     int'(ped_ack),  0);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n)  chk("excl_lamps",  int'(light_a  != 3'b100 && light_b  != 3'b100), 0);
    if (rst2_n) chk("excl_lamps2", int'(light_a2 != 3'b100 && light_b2 != 3'b100), 0);
  end

  initial begin
    tl_state_e ph2[10];
    int        cn2[10];

    rst_n = 1'b0; enable = 1'b0; ped_req = 1'b0;
    rst2_n = 1'b0; en2 = 1'b1; req2 = 1'b0;
    #1;
    chk("rst_phase",   int'(phase),    int'(ALLRED_A));
    chk("rst_count",   int'(count),    0);
    chk("rst_light_a", int'(light_a),  4);
    chk("rst_light_b", int'(light_b),  4);
    chk("rst_walk",    int'(ped_walk), 0);
    chk("rst_ack",     int'(ped_ack),  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain 34-cycle period
    add(ALLRED_A, 2, 0, 1, 1, 0, 0);
    add(A_GREEN, 10, 0, 1, 1, 0, 0);
    add(A_YELLOW, 5, 0, 1, 1, 0, 0);
    add(ALLRED_B, 2, 0, 1, 1, 0, 0);
    add(B_GREEN, 10, 0, 1, 1, 0, 0);
    add(B_YELLOW, 5, 0, 1, 1, 0, 0);
    add(ALLRED_A, 2, 0, 1, 1, 0, 0);
    // Single pulse at A_GREEN count 3 -> walk after ALLRED_B, then B green
    add(A_GREEN,  3, 0, 1, 1, 0, 0);
    add(A_GREEN,  1, 3, 1, 1, 1, 0);
    add(A_GREEN,  6, 4, 1, 1, 0, 0);
    add(A_YELLOW, 5, 0, 1, 1, 0, 0);
    add(ALLRED_B, 2, 0, 1, 1, 0, 0);
    add(WALK,     8, 0, 1, 1, 0, 1);
    // Drop enable at B_GREEN count 4, hold off, then restart
    add(B_GREEN,  4, 0, 1, 1, 0, 0);
    add(B_GREEN,  1, 4, 1, 0, 0, 0);
    add(ALLRED_A, 3, 0, 0, 0, 0, 0);
    add(ALLRED_A, 2, 0, 1, 1, 0, 0);
    // Held request: a walk at every all-red boundary, never back to back
    add(A_GREEN, 10, 0, 1, 1, 1, 0);
    add(A_YELLOW, 5, 0, 1, 1, 1, 0);
    add(ALLRED_B, 2, 0, 1, 1, 1, 0);
    add(WALK,     8, 0, 1, 1, 1, 1);
    add(B_GREEN, 10, 0, 1, 1, 1, 0);
    add(B_YELLOW, 5, 0, 1, 1, 1, 0);
    add(ALLRED_A, 2, 0, 1, 1, 1, 0);
    add(WALK,     8, 0, 1, 1, 1, 1);
    add(A_GREEN, 10, 0, 1, 1, 1, 0);
    add(A_YELLOW, 5, 0, 1, 1, 1, 0);
    add(ALLRED_B, 2, 0, 1, 1, 0, 0);
    add(WALK,     8, 0, 1, 1, 0, 1);
    add(B_GREEN, 10, 0, 1, 1, 0, 0);
    add(B_YELLOW, 5, 0, 1, 1, 0, 0);
    add(ALLRED_A, 2, 0, 1, 1, 0, 0);
    add(A_GREEN,  3, 0, 1, 1, 0, 0);

    foreach (tbl[k]) run_seg(tbl[k]);

    // Reset in the middle of WALK
    seg(A_GREEN,  1, 3, 1, 0);
    seg(A_GREEN,  6, 4, 0, 0);
    seg(A_YELLOW, 5, 0, 0, 0);
    seg(ALLRED_B, 2, 0, 0, 0);
    seg(WALK,     3, 0, 0, 1);
    async_reset("rst_walk");
    seg(ALLRED_A, 2, 0, 0, 0);
    seg(A_GREEN,  2, 0, 0, 0);

    // Pending request wiped by reset: ALLRED_A must lead to A_GREEN, not WALK
    seg(A_GREEN,  1, 2, 1, 0);
    async_reset("rst_pend");
    seg(ALLRED_A, 2, 0, 0, 0);
    seg(A_GREEN,  1, 0, 0, 0);

    // Short-timing instance: period 10
    ph2 = '{ALLRED_A, A_GREEN, A_GREEN, A_GREEN, A_YELLOW,
            ALLRED_B, B_GREEN, B_GREEN, B_GREEN, B_YELLOW};
    cn2 = '{0, 0, 1, 2, 0, 0, 0, 1, 2, 0};
    @(negedge clk);
    rst2_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      chk("phase2",   int'(phase2),   int'(ph2[i % 10]));
      chk("count2",   int'(count2),   cn2[i % 10]);
      chk("light_a2", int'(light_a2), int'(exp_a(ph2[i % 10])));
      chk("light_b2", int'(light_b2), int'(exp_b(ph2[i % 10])));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
